dmem_access_ctrl: RTL and testbench

Sequencer between the pipeline's MEM stage and a variable-latency data memory with a req/ack handshake. It latches each load/store from the EX/MEM register and drives the memory transaction. It freezes the pipeline with `stall_o` until the memory acknowledges, then returns the load data to MEM/WB. A watchdog traps accesses that never complete.

---
 rtl/dmem_access_ctrl_if.sv | 22 ++
 rtl/dmem_access_ctrl.sv | 93 +++++++++
 tb/tb_dmem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access sequencer (master) and a
// variable-latency data memory (slave) using a req/ack handshake.
interface dmem_access_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: latches a load/store, drives a req/ack
// transaction, stalls the pipeline until completion and traps hung accesses.
module dmem_access_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o,
  dmem_access_ctrl_if.master dm
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e            r_state, w_state_next;
  logic [7:0]        r_wait_cnt, w_wait_cnt_next;
  logic              r_we;
  logic [DATA_W-1:0] r_addr, r_wdata, r_rdata;
  logic              w_access, w_latch, w_capture;

  assign w_access = mem_read_i | mem_write_i;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_latch         = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_access) begin
          w_latch         = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = StReq;
        end
      end
      StReq: begin
        // An ack in the final allowed cycle still completes the access.
        if (dm.dm_ack) begin
          w_capture    = ~r_we;
          w_state_next = StDone;
        end else if (r_wait_cnt == WaitLast) begin
          w_state_next = StErr;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end
      StDone:  w_state_next = StIdle;
      StErr:   w_state_next = StErr;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_latch) begin
        r_we    <= mem_write_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      if (w_capture) begin
        r_rdata <= dm.dm_rdata;
      end
    end
  end

  assign dm.dm_req   = (r_state == StReq);
  assign dm.dm_we    = r_we;
  assign dm.dm_addr  = r_addr;
  assign dm.dm_wdata = r_wdata;
  assign rdata_o     = r_rdata;
  assign err_o       = (r_state == StErr);
  // The IDLE term freezes the pipeline in the very cycle the access appears.
  assign stall_o     = ((r_state == StIdle) & w_access) | (r_state == StReq) |
                       (r_state == StErr);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_dmem_access_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst, rd, wr;
  logic [DW-1:0] addr, wdata, rdata;
  logic          stall, err;

  dmem_access_ctrl_if #(.DATA_W(DW)) dm ();

  dmem_access_ctrl #(.DATA_W(DW), .MAX_WAIT(MW)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_read_i (rd),
    .mem_write_i(wr),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .stall_o    (stall),
    .err_o      (err),
    .dm         (dm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the access as the spec describes it, tracked per phase.
  typedef enum int {MIdle, MReq, MDone, MErr} mphase_e;
  mphase_e       m_phase;
  int            m_req_cycles;
  logic          m_we;
  logic [DW-1:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_phase      <= MIdle;
      m_req_cycles <= 0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_rdata      <= '0;
    end else begin
      case (m_phase)
        MIdle: if (rd || wr) begin
          m_we         <= wr;
          m_addr       <= addr;
          m_wdata      <= wdata;
          m_req_cycles <= 0;
          m_phase      <= MReq;
        end
        MReq: begin
          m_req_cycles <= m_req_cycles + 1;
          if (dm.dm_ack) begin
            if (!m_we) m_rdata <= dm.dm_rdata;
            m_phase <= MDone;
          end else if (m_req_cycles + 1 >= int'(MW)) begin
            m_phase <= MErr;
          end
        end
        MDone:   m_phase <= MIdle;
        default: m_phase <= m_phase;
      endcase
    end
  end

  // Observation counters used by the directed scenarios.
  int            n_stall, n_req, n_txn;
  logic          prev_req;
  logic          last_we;
  logic [DW-1:0] last_addr, last_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall),
            32'(((m_phase == MIdle) && (rd || wr)) || m_phase == MReq || m_phase == MErr));
      check("dm_req", 32'(dm.dm_req), 32'(m_phase == MReq));
      check("dm_we", 32'(dm.dm_we), 32'(m_we));
      check("dm_addr", dm.dm_addr, m_addr);
      check("dm_wdata", dm.dm_wdata, m_wdata);
      check("rdata", rdata, m_rdata);
      check("err", 32'(err), 32'(m_phase == MErr));
      if (stall) n_stall++;
      if (dm.dm_req) begin
        n_req++;
        if (!prev_req) n_txn++;
        last_we    = dm.dm_we;
        last_addr  = dm.dm_addr;
        last_wdata = dm.dm_wdata;
      end
      prev_req = dm.dm_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_stall  = 0;
    n_req    = 0;
    n_txn    = 0;
    prev_req = 1'b0;
  endtask

  task automatic idle_in();
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    clr();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_req", 32'(dm.dm_req), 32'h0);
    check("rst_we", 32'(dm.dm_we), 32'h0);
    check("rst_addr", dm.dm_addr, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // Load, immediate ack
    clr();
    rd = 1'b1; addr = 32'h10;
    step();
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hDEADBEEF;
    step();
    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
    check("ld_rdata_done", rdata, 32'hDEADBEEF);
    step();
    rd = 1'b0;
    step();
    check("ld_stall_cycles", 32'(n_stall), 32'd2);
    check("ld_req_cycles", 32'(n_req), 32'd1);
    check("ld_we", 32'(last_we), 32'h0);
    check("ld_addr", last_addr, 32'h10);
    check("ld_rdata", rdata, 32'hDEADBEEF);

    // Store, ack in the fourth REQ cycle
    clr();
    wr = 1'b1; addr = 32'h20; wdata = 32'h1234;
    step();
    addr = 32'h0; wdata = 32'h0;
    repeat (3) step();
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hBAD0BAD0;
    step();
    dm.dm_ack = 1'b0;
    step();
    wr = 1'b0;
    step();
    check("st_stall_cycles", 32'(n_stall), 32'd5);
    check("st_req_cycles", 32'(n_req), 32'd4);
    check("st_we", 32'(last_we), 32'h1);
    check("st_addr", last_addr, 32'h20);
    check("st_wdata", last_wdata, 32'h1234);
    check("st_rdata_kept", rdata, 32'hDEADBEEF);

    // Back-to-back load then store
    clr();
    rd = 1'b1; addr = 32'h30;
    step();
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hCAFE0001;
    step();
    dm.dm_ack = 1'b0;
    step();
    rd = 1'b0; wr = 1'b1; addr = 32'h40; wdata = 32'h55;
    step();
    dm.dm_ack = 1'b1;
    step();
    dm.dm_ack = 1'b0;
    step();
    wr = 1'b0;
    check("b2b_txn", 32'(n_txn), 32'd2);
    check("b2b_req_cycles", 32'(n_req), 32'd2);
    check("b2b_stall_cycles", 32'(n_stall), 32'd4);
    check("b2b_last_addr", last_addr, 32'h40);
    check("b2b_rdata", rdata, 32'hCAFE0001);

    // Stray ack in IDLE
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hFFFF;
    step();
    idle_in();
    step();
    check("stray_rdata", rdata, 32'hCAFE0001);
    check("stray_req", 32'(dm.dm_req), 32'h0);

    // Simultaneous read/write, then reset mid-REQ
    rd = 1'b1; wr = 1'b1; addr = 32'h50; wdata = 32'h77;
    step();
    check("rw_req", 32'(dm.dm_req), 32'h1);
    check("rw_we", 32'(dm.dm_we), 32'h1);
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    step();
    rst = 1'b0;
    check("mrst_req", 32'(dm.dm_req), 32'h0);
    check("mrst_we", 32'(dm.dm_we), 32'h0);
    check("mrst_addr", dm.dm_addr, 32'h0);
    check("mrst_wdata", dm.dm_wdata, 32'h0);
    check("mrst_rdata", rdata, 32'h0);
    check("mrst_stall", 32'(stall), 32'h0);

    // Timeout with no ack
    clr();
    rd = 1'b1; addr = 32'h60;
    step();
    repeat (MW) step();
    check("to_req_cycles", 32'(n_req), 32'(MW));
    check("to_err", 32'(err), 32'h1);
    check("to_req_low", 32'(dm.dm_req), 32'h0);
    check("to_stall", 32'(stall), 32'h1);
    rd = 1'b0; dm.dm_ack = 1'b1; dm.dm_rdata = 32'h1;
    step();
    dm.dm_ack = 1'b0;
    step();
    check("to_late_ack_err", 32'(err), 32'h1);
    check("to_late_ack_rdata", rdata, 32'h0);
    check("to_late_ack_stall", 32'(stall), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("to_rst_err", 32'(err), 32'h0);
    check("to_rst_stall", 32'(stall), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      rd           = ($urandom_range(0, 2) == 0);
      wr           = ($urandom_range(0, 3) == 0);
      addr         = $urandom;
      wdata        = $urandom;
      dm.dm_ack    = ($urandom_range(0, 1) == 0);
      dm.dm_rdata  = $urandom;
      step();
    end
    idle_in();
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
